// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus between decode and the ALU: control/operands in, result and zero flag out.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       ALUop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [3:0]       ALUctrl;
    logic [WIDTH-1:0] out;
    logic             Zero;

    modport master (
        output ALUop,
        output funct,
        output input1,
        output input2,
        input  ALUctrl,
        input  out,
        input  Zero
    );

    modport slave (
        input  ALUop,
        input  funct,
        input  input1,
        input  input2,
        output ALUctrl,
        output out,
        output Zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS-style ALU control decoder feeding a WIDTH-bit integer ALU.
// The result and zero flag are registered, giving one cycle of latency.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_BAD = 4'b1111;

    logic [3:0]       ctrl;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;

    // Control decode: memory ops add, branches subtract, R-type uses funct.
    always_comb begin
        ctrl = CTRL_BAD;
        unique case (bus.ALUop)
            2'b00: ctrl = CTRL_ADD;
            2'b01,
            2'b11: ctrl = CTRL_SUB;
            2'b10: begin
                unique case (bus.funct)
                    6'b100000: ctrl = CTRL_ADD;
                    6'b100010: ctrl = CTRL_SUB;
                    6'b100100: ctrl = CTRL_AND;
                    6'b100101: ctrl = CTRL_OR;
                    6'b101010: ctrl = CTRL_SLT;
                    6'b100111: ctrl = CTRL_NOR;
                    default:   ctrl = CTRL_BAD;
                endcase
            end
            default: ctrl = CTRL_BAD;
        endcase
    end

    // Datapath; unsupported codes yield zero.
    always_comb begin
        result = '0;
        unique case (ctrl)
            CTRL_AND: result = bus.input1 & bus.input2;
            CTRL_OR:  result = bus.input1 | bus.input2;
            CTRL_ADD: result = bus.input1 + bus.input2;
            CTRL_SUB: result = bus.input1 - bus.input2;
            CTRL_SLT: result = ($signed(bus.input1) < $signed(bus.input2)) ? WIDTH'(1) : '0;
            CTRL_NOR: result = ~(bus.input1 | bus.input2);
            default:  result = '0;
        endcase
    end

    // Zero is derived from the same value that loads out so the pair never disagrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= result;
            zero_q <= (result == '0);
        end
    end

    assign bus.ALUctrl = ctrl;
    assign bus.out     = out_q;
    assign bus.Zero    = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, reset/pipelining sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference decode, written from the opcode table.
    function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01 || op == 2'b11) return 4'b0110;
        if (f == 6'h20) return 4'b0010;
        if (f == 6'h22) return 4'b0110;
        if (f == 6'h24) return 4'b0000;
        if (f == 6'h25) return 4'b0001;
        if (f == 6'h2A) return 4'b0111;
        if (f == 6'h27) return 4'b1100;
        return 4'b1111;
    endfunction

    // Reference ALU using wide integer arithmetic reduced modulo 2^32.
    function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned wa;
        longint unsigned wb;
        longint unsigned two32;
        wa    = 64'(a);
        wb    = 64'(b);
        two32 = 64'h1_0000_0000;
        if (c == 4'b0000) return a & b;
        if (c == 4'b0001) return a | b;
        if (c == 4'b0010) return 32'((wa + wb) % two32);
        if (c == 4'b0110) return 32'((wa + two32 - wb) % two32);
        if (c == 4'b0111) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        if (c == 4'b1100) return ~(a | b);
        return 32'd0;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.ALUop  = op;
        bus.funct  = f;
        bus.input1 = a;
        bus.input2 = b;
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] e;
        logic [5:0]  fsel[7];
        logic [3:0]  c;
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        clk     = 1'b0;
        rst     = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        drive(2'b00, 6'h00, 32'd5, 32'd10);

        vecs[0]  = '{2'b00, 6'h00, 32'd5, 32'd10, 4'b0010, 32'h0000000F, 1'b0};
        vecs[1]  = '{2'b01, 6'h00, 32'd5, 32'd10, 4'b0110, 32'hFFFFFFFB, 1'b0};
        vecs[2]  = '{2'b11, 6'h00, 32'd5, 32'd10, 4'b0110, 32'hFFFFFFFB, 1'b0};
        vecs[3]  = '{2'b10, 6'h20, 32'd5, 32'd10, 4'b0010, 32'h0000000F, 1'b0};
        vecs[4]  = '{2'b10, 6'h24, 32'd5, 32'd10, 4'b0000, 32'h00000000, 1'b1};
        vecs[5]  = '{2'b10, 6'h25, 32'd5, 32'd10, 4'b0001, 32'h0000000F, 1'b0};
        vecs[6]  = '{2'b10, 6'h2A, 32'd5, 32'd10, 4'b0111, 32'h00000001, 1'b0};
        vecs[7]  = '{2'b10, 6'h22, 32'd5, 32'd10, 4'b0110, 32'hFFFFFFFB, 1'b0};
        vecs[8]  = '{2'b10, 6'h27, 32'd5, 32'd10, 4'b1100, 32'hFFFFFFF0, 1'b0};
        vecs[9]  = '{2'b10, 6'h00, 32'd5, 32'd10, 4'b1111, 32'h00000000, 1'b1};
        vecs[10] = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0};
        vecs[11] = '{2'b10, 6'h2A, 32'h00000001, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1};
        vecs[12] = '{2'b01, 6'h00, 32'd7, 32'd7, 4'b0110, 32'h00000000, 1'b1};
        vecs[13] = '{2'b00, 6'h00, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1};

        // Reset held for two edges overrides the 5+10 result.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_out", bus.out, 32'h0);
            check("reset_zero", 32'(bus.Zero), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_out", bus.out, 32'h0000000F);
        check("post_reset_zero", 32'(bus.Zero), 32'd0);

        // Directed vectors: ALUctrl same cycle, out/Zero after the next edge.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d_ctrl", i), 32'(bus.ALUctrl), 32'(vecs[i].exp_ctrl));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
            check($sformatf("vec%0d_zero", i), 32'(bus.Zero), 32'(vecs[i].exp_zero));
        end

        // Back-to-back operands with a reset pulse in the middle: each result lags by one edge.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                check($sformatf("pipe%0d_out", i), bus.out, e);
                check($sformatf("pipe%0d_zero", i), 32'(bus.Zero), 32'(e == 32'h0));
            end
            if (i < 8) begin
                a = $urandom;
                b = $urandom;
                drive(2'b00, 6'h00, a, b);
                rst = (i == 4);
                exp_q.push_back(rst ? 32'h0 : a + b);
            end else begin
                rst = 1'b0;
            end
        end

        // Randomized operations against the reference model.
        fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 5)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
            drive(op, f, a, b);
            c = model_ctrl(op, f);
            e = model_alu(c, a, b);
            #1;
            check($sformatf("rnd%0d_ctrl", i), 32'(bus.ALUctrl), 32'(c));
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_out", i), bus.out, e);
            check($sformatf("rnd%0d_zero", i), 32'(bus.Zero), 32'(e == 32'h0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
